gate_truth_sequencer: RTL

//  Exhaustive truth-table test controller for one combinational gate of the Lab1 gate set.

---
 rtl/gate_lab_pkg.sv | 33 +++
 rtl/gate_settle_timer.sv | 44 ++++
 rtl/gate_truth_sequencer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/gate_lab_pkg.sv
`default_nettype none
// ============================================================================
// Package : gate_lab_pkg
// Brief   : Shared types, helpers and truth-table constants for the Lab1
//           gate set and its truth-table sequencer.
// Rev     : 1.0
// ============================================================================
package gate_lab_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Width of the settle counter; holds SETTLE_CYCLES-1 for SETTLE_CYCLES up to 15.
    localparam int unsigned CNT_W = 4;

    // Bit i is the gate output for input pattern i (bit 1 = input A, bit 0 = input B).
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_XNOR = 4'b1001;

    function automatic int unsigned N_VEC(input int unsigned n_in);
        return 32'd1 << n_in;
    endfunction

endpackage : gate_lab_pkg
`default_nettype wire

// File: rtl/gate_settle_timer.sv
`default_nettype none
// ============================================================================
// Module : gate_settle_timer
// Brief  : Loadable down-counter; flags zero so the sequencer knows the gate
//          input has been held long enough.
// Rev    : 1.0
// ============================================================================
module gate_settle_timer
    import gate_lab_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule : gate_settle_timer
`default_nettype wire

// File: rtl/gate_truth_sequencer.sv
`default_nettype none
// ============================================================================
// Module : gate_truth_sequencer
// Brief  : Walks a combinational gate through every input pattern, samples its
//          output and compares the collected table against an expected table.
// Rev    : 1.0
// ============================================================================
module gate_truth_sequencer
    import gate_lab_pkg::*;
#(
    parameter int unsigned N_IN          = 2,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [N_VEC(N_IN)-1:0]  expected,
    output logic [N_IN-1:0]         dut_in,
    input  logic                    dut_out,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [N_VEC(N_IN)-1:0]  result_vec,
    output logic [N_VEC(N_IN)-1:0]  fail_mask
);

    localparam int unsigned      NV     = N_VEC(N_IN);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [N_IN:0]    LAST   = (N_IN + 1)'(NV - 1);

    state_t            state_q,  state_d;
    logic [N_IN:0]     idx_q,    idx_d;
    logic [N_IN-1:0]   dut_in_q, dut_in_d;
    logic [NV-1:0]     exp_q,    exp_d;
    logic [NV-1:0]     res_q,    res_d;
    logic [NV-1:0]     mask_q,   mask_d;
    logic              pass_q,   pass_d;
    logic              done_q,   done_d;

    logic              tmr_load;
    logic              tmr_en;
    logic              tmr_zero;

    gate_settle_timer #(
        .WIDTH    (CNT_W)
    ) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (RELOAD),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        dut_in_d = dut_in_q;
        exp_d    = exp_q;
        res_d    = res_q;
        mask_d   = mask_q;
        pass_d   = pass_q;
        done_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;

        case (state_q)
            IDLE: begin
                // Abort outranks start so a cancelled request never begins a run.
                if (start && !abort) begin
                    exp_d    = expected;
                    res_d    = '0;
                    mask_d   = '0;
                    pass_d   = 1'b0;
                    idx_d    = '0;
                    dut_in_d = '0;
                    tmr_load = 1'b1;
                    state_d  = SETTLE;
                end
            end

            SETTLE: begin
                if (abort) begin
                    state_d  = IDLE;
                    idx_d    = '0;
                    dut_in_d = '0;
                    pass_d   = 1'b0;
                end else if (tmr_zero) begin
                    state_d  = SAMPLE;
                end else begin
                    tmr_en   = 1'b1;
                end
            end

            SAMPLE: begin
                if (abort) begin
                    state_d  = IDLE;
                    idx_d    = '0;
                    dut_in_d = '0;
                    pass_d   = 1'b0;
                end else begin
                    res_d[idx_q[N_IN-1:0]] = dut_out;
                    // Last vector is caught before incrementing, so idx never wraps.
                    if (idx_q == LAST) begin
                        state_d  = DONE;
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        dut_in_d = idx_d[N_IN-1:0];
                        tmr_load = 1'b1;
                        state_d  = SETTLE;
                    end
                end
            end

            DONE: begin
                done_d  = 1'b1;
                mask_d  = res_q ^ exp_q;
                pass_d  = (res_q == exp_q);
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            dut_in_q <= '0;
            exp_q    <= '0;
            res_q    <= '0;
            mask_q   <= '0;
            pass_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            dut_in_q <= dut_in_d;
            exp_q    <= exp_d;
            res_q    <= res_d;
            mask_q   <= mask_d;
            pass_q   <= pass_d;
            done_q   <= done_d;
        end
    end

    assign dut_in     = dut_in_q;
    assign busy       = (state_q == SETTLE) || (state_q == SAMPLE);
    assign done       = done_q;
    assign pass       = pass_q;
    assign result_vec = res_q;
    assign fail_mask  = mask_q;

endmodule : gate_truth_sequencer
`default_nettype wire
